// File: rtl/pacman_key_dir.sv
// Keyboard arrow-key to Pac-Man direction controller: tracks pressed arrows,
// keeps one active direction, and lingers for HOLD_FRAMES frames after a quick tap.
module pacman_key_dir #(
    parameter logic [8:0]  KEY_UP      = 9'h175,
    parameter logic [8:0]  KEY_DOWN    = 9'h172,
    parameter logic [8:0]  KEY_LEFT    = 9'h16B,
    parameter logic [8:0]  KEY_RIGHT   = 9'h174,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brake,
    input  logic       collision_ghost_smiley,
    output logic       Y_direction_key,
    output logic       toggle_x_key,
    output logic       Y_direction_key_up,
    output logic       toggle_x_key_left
);

    // state   | meaning
    // IDLE_ST | no active direction
    // HELD_ST | active key is physically held
    // TAP_ST  | active key released, frame countdown running
    typedef enum logic [1:0] {IDLE_ST, HELD_ST, TAP_ST} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t      state_q, state_d;
    dir_t        active_q, active_d;
    logic [3:0]  mask_q, mask_d;      // bit0 up, bit1 down, bit2 left, bit3 right
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  out_q, out_d;        // {up, down, left, right}

    logic [3:0]  key_bit;
    dir_t        key_dir;
    logic        make_ok, brake_ok;

    always_comb begin
        key_bit = 4'b0000;
        key_dir = DIR_NONE;
        if (keyCode == KEY_UP) begin
            key_bit = 4'b0001;
            key_dir = DIR_UP;
        end else if (keyCode == KEY_DOWN) begin
            key_bit = 4'b0010;
            key_dir = DIR_DOWN;
        end else if (keyCode == KEY_LEFT) begin
            key_bit = 4'b0100;
            key_dir = DIR_LEFT;
        end else if (keyCode == KEY_RIGHT) begin
            key_bit = 4'b1000;
            key_dir = DIR_RIGHT;
        end
    end

    // A simultaneous make and brake is treated as a glitch and dropped.
    assign make_ok  = make  && !brake && (key_bit != 4'b0000);
    assign brake_ok = brake && !make  && (key_bit != 4'b0000);

    function automatic dir_t prio_dir(input logic [3:0] m);
        dir_t d;
        d = DIR_NONE;
        if (m[0])      d = DIR_UP;
        else if (m[1]) d = DIR_DOWN;
        else if (m[2]) d = DIR_LEFT;
        else if (m[3]) d = DIR_RIGHT;
        return d;
    endfunction

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        if (collision_ghost_smiley) begin
            state_d  = IDLE_ST;
            active_d = DIR_NONE;
            mask_d   = 4'b0000;
            cnt_d    = 4'd0;
        end else if (make_ok) begin
            mask_d   = mask_q | key_bit;
            active_d = key_dir;
            state_d  = HELD_ST;
        end else begin
            if (brake_ok) begin
                mask_d = mask_q & ~key_bit;
            end
            case (state_q)
                HELD_ST: begin
                    if (brake_ok && (key_dir == active_q)) begin
                        if (mask_d != 4'b0000) begin
                            active_d = prio_dir(mask_d);
                        end else begin
                            state_d = TAP_ST;
                            cnt_d   = 4'(HOLD_FRAMES);
                        end
                    end
                end
                TAP_ST: begin
                    if (startOfFrame) begin
                        if (cnt_q <= 4'd1) begin
                            state_d  = IDLE_ST;
                            active_d = DIR_NONE;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_d = 4'b0000;
        case (active_d)
            DIR_UP:    out_d = 4'b1000;
            DIR_DOWN:  out_d = 4'b0100;
            DIR_LEFT:  out_d = 4'b0010;
            DIR_RIGHT: out_d = 4'b0001;
            default:   out_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE_ST;
            active_q <= DIR_NONE;
            mask_q   <= 4'b0000;
            cnt_q    <= 4'd0;
            out_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign Y_direction_key_up = out_q[3];
    assign Y_direction_key    = out_q[2];
    assign toggle_x_key_left  = out_q[1];
    assign toggle_x_key       = out_q[0];

endmodule

// File: tb/tb_pacman_key_dir.sv
// Directed and randomized checks of pacman_key_dir against a behavioural
// model of the pressed keys, active direction and tap countdown.
module tb_pacman_key_dir;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       collision_ghost_smiley;
    logic       Y_direction_key, toggle_x_key, Y_direction_key_up, toggle_x_key_left;

    int checks = 0;
    int failures = 0;

    // Model: pressed[i] in priority order up, down, left, right; act = -1 for none.
    bit pressed [4];
    int act;
    bit tapping;
    int frames_left;

    pacman_key_dir #(.HOLD_FRAMES(HOLD)) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .keyCode                (keyCode),
        .make                   (make),
        .brake                  (brake),
        .collision_ghost_smiley (collision_ghost_smiley),
        .Y_direction_key        (Y_direction_key),
        .toggle_x_key           (toggle_x_key),
        .Y_direction_key_up     (Y_direction_key_up),
        .toggle_x_key_left      (toggle_x_key_left)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_out();
        return {Y_direction_key_up, Y_direction_key, toggle_x_key_left, toggle_x_key};
    endfunction

    function automatic logic [3:0] model_out();
        logic [3:0] v;
        v = 4'b0000;
        if (act >= 0) v[3 - act] = 1'b1;
        return v;
    endfunction

    function automatic int key_index(input logic [8:0] code);
        case (code)
            9'h175:  return 0;
            9'h172:  return 1;
            9'h16B:  return 2;
            9'h174:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) pressed[i] = 1'b0;
        act = -1;
        tapping = 1'b0;
        frames_left = 0;
    endtask

    task automatic model_edge(input bit mk, input bit bk, input logic [8:0] code,
                              input bit sof, input bit col);
        int k;
        bit brk;
        k = key_index(code);
        brk = bk && !mk && (k >= 0);
        if (col) begin
            model_reset();
        end else if (mk && !bk && k >= 0) begin
            pressed[k] = 1'b1;
            act = k;
            tapping = 1'b0;
        end else begin
            if (brk) pressed[k] = 1'b0;
            if (act >= 0 && !tapping) begin
                if (brk && k == act) begin
                    act = -1;
                    for (int i = 3; i >= 0; i--) if (pressed[i]) act = i;
                    if (act < 0) begin
                        act = k;
                        tapping = 1'b1;
                        frames_left = HOLD;
                    end
                end
            end else if (tapping && sof) begin
                frames_left--;
                if (frames_left == 0) begin
                    act = -1;
                    tapping = 1'b0;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input string tag, input bit mk, input bit bk, input logic [8:0] code,
                        input bit sof, input bit col);
        make = mk;
        brake = bk;
        keyCode = code;
        startOfFrame = sof;
        collision_ghost_smiley = col;
        @(posedge clk);
        model_edge(mk, bk, code, sof, col);
        #1;
        chk(tag, dut_out(), model_out());
        make = 1'b0;
        brake = 1'b0;
        startOfFrame = 1'b0;
        collision_ghost_smiley = 1'b0;
    endtask

    initial begin
        logic [8:0] codes [5];
        codes[0] = 9'h175; codes[1] = 9'h172; codes[2] = 9'h16B;
        codes[3] = 9'h174; codes[4] = 9'h01C;

        resetN = 1'b0;
        make = 1'b0; brake = 1'b0; keyCode = 9'h000;
        startOfFrame = 1'b0; collision_ghost_smiley = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", dut_out(), 4'b0000);
        resetN = 1'b1;

        // Right held across 10 frames.
        step("r18_make_right", 1, 0, 9'h174, 0, 0);
        chk("r18_right_only", dut_out(), 4'b0001);
        for (int i = 0; i < 10; i++) step("r18_hold", 0, 0, 9'h174, 1, 0);
        chk("r18_still_right", dut_out(), 4'b0001);
        step("r18_release", 0, 1, 9'h174, 0, 0);
        for (int i = 0; i < HOLD; i++) step("r18_drain", 0, 0, 9'h000, 1, 0);
        chk("r18_drained", dut_out(), 4'b0000);

        // Tap up: lingers through HOLD-1 frames, drops after the last.
        step("r19_make_up", 1, 0, 9'h175, 0, 0);
        step("r19_brake_up", 0, 1, 9'h175, 0, 0);
        chk("r19_after_brake", dut_out(), 4'b1000);
        for (int i = 0; i < HOLD - 1; i++) begin
            step("r19_frame", 0, 0, 9'h000, 1, 0);
            chk("r19_linger", dut_out(), 4'b1000);
        end
        step("r19_last_frame", 0, 0, 9'h000, 1, 0);
        chk("r19_dropped", dut_out(), 4'b0000);

        // Left, then down, then release down returns to left.
        step("r20_left", 1, 0, 9'h16B, 0, 0);
        chk("r20_left_out", dut_out(), 4'b0010);
        step("r20_down", 1, 0, 9'h172, 0, 0);
        chk("r20_down_out", dut_out(), 4'b0100);
        step("r20_brake_down", 0, 1, 9'h172, 0, 0);
        chk("r20_back_left", dut_out(), 4'b0010);
        step("r20_brake_left", 0, 1, 9'h16B, 0, 0);
        for (int i = 0; i < HOLD; i++) step("r20_drain", 0, 0, 9'h000, 1, 0);

        // Collision overrides a same-cycle make; held right stays dead.
        step("r21_right", 1, 0, 9'h174, 0, 0);
        step("r21_collide", 1, 0, 9'h175, 0, 1);
        chk("r21_cleared", dut_out(), 4'b0000);
        for (int i = 0; i < 5; i++) step("r21_quiet", 0, 0, 9'h000, 1, 0);
        chk("r21_still_zero", dut_out(), 4'b0000);
        step("r21_stale_brake", 0, 1, 9'h174, 0, 0);
        chk("r21_stale_zero", dut_out(), 4'b0000);
        step("r21_new_make", 1, 0, 9'h16B, 0, 0);
        chk("r21_new_left", dut_out(), 4'b0010);

        // Unmapped code and glitch make+brake leave left active.
        step("r22_unmapped_make", 1, 0, 9'h01C, 0, 0);
        step("r22_unmapped_brake", 0, 1, 9'h01C, 0, 0);
        step("r22_both", 1, 1, 9'h174, 0, 0);
        chk("r22_unchanged", dut_out(), 4'b0010);
        step("r22_typematic", 1, 0, 9'h16B, 1, 0);
        chk("r22_typematic_same", dut_out(), 4'b0010);

        // Reset during a tap countdown.
        step("r23_brake_left", 0, 1, 9'h16B, 0, 0);
        step("r23_frame", 0, 0, 9'h000, 1, 0);
        chk("r23_in_tap", dut_out(), 4'b0010);
        resetN = 1'b0;
        #1;
        chk("r23_async_clear", dut_out(), 4'b0000);
        model_reset();
        @(posedge clk);
        #1;
        chk("r23_held_reset", dut_out(), 4'b0000);
        resetN = 1'b1;
        step("r23_make_down", 1, 0, 9'h172, 0, 0);
        chk("r23_down_out", dut_out(), 4'b0100);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            bit mk, bk;
            r = $urandom_range(0, 99);
            mk = (r < 25) || (r >= 95);
            bk = (r >= 25 && r < 50) || (r >= 95);
            step("rand", mk, bk, codes[$urandom_range(0, 4)],
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (!$onehot0(dut_out())) begin
                failures++;
                $display("FAIL rand_onehot got=%b expected=at_most_one_high", dut_out());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
